// File: rtl/pwm_deadtime.sv
// Complementary PWM driver with double-buffered duty/dead-time registers and
// a dead-time FSM that keeps both drives low while switching sides.
module pwm_deadtime #(
    parameter int N    = 8,
    parameter int DT_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N-1:0]    cnt,
    input  logic            period_strobe,
    input  logic            wr_en,
    input  logic [N-1:0]    duty_in,
    input  logic [DT_W-1:0] dt_in,
    output logic            pwm_h,
    output logic            pwm_l,
    output logic            pending
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        DEAD
    } state_t;

    localparam logic [DT_W-1:0] DT_ONE = DT_W'(1);

    state_t          state_q, state_d;
    logic            tgt_q, tgt_d;
    logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
    logic            raw_q;
    logic [N-1:0]    duty_stg_q, duty_act_q;
    logic [DT_W-1:0] dt_stg_q, dt_act_q;
    logic            pending_q;
    logic            pwm_h_q, pwm_l_q;
    logic            switch_req;
    logic [DT_W-1:0] dt_load;

    // A zero dead-time restart wraps the down-counter to all-ones.
    assign dt_load = dt_act_q - DT_ONE;

    assign switch_req = (state_q == IDLE)
                     || ((state_q == HIGH) && !raw_q)
                     || ((state_q == LOW)  &&  raw_q);

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        dt_cnt_d = dt_cnt_q;
        if (!en) begin
            state_d = IDLE;
        end else if (switch_req) begin
            tgt_d = raw_q;
            if (dt_act_q == '0) begin
                state_d = raw_q ? HIGH : LOW;
            end else begin
                state_d  = DEAD;
                dt_cnt_d = dt_load;
            end
        end else if (state_q == DEAD) begin
            if (raw_q != tgt_q) begin
                tgt_d    = raw_q;
                dt_cnt_d = dt_load;
            end else if (dt_cnt_q == '0) begin
                state_d = tgt_q ? HIGH : LOW;
            end else begin
                dt_cnt_d = dt_cnt_q - DT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tgt_q      <= 1'b0;
            dt_cnt_q   <= '0;
            raw_q      <= 1'b0;
            duty_stg_q <= '0;
            duty_act_q <= '0;
            dt_stg_q   <= '0;
            dt_act_q   <= '0;
            pending_q  <= 1'b0;
            pwm_h_q    <= 1'b0;
            pwm_l_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            dt_cnt_q <= dt_cnt_d;
            raw_q    <= en && (cnt < duty_act_q);
            pwm_h_q  <= (state_d == HIGH);
            pwm_l_q  <= (state_d == LOW);

            // Active registers always see the pre-write staging contents.
            if (period_strobe && pending_q) begin
                duty_act_q <= duty_stg_q;
                dt_act_q   <= dt_stg_q;
            end
            if (wr_en) begin
                duty_stg_q <= duty_in;
                dt_stg_q   <= dt_in;
                pending_q  <= 1'b1;
            end else if (period_strobe) begin
                pending_q  <= 1'b0;
            end
        end
    end

    assign pwm_h   = pwm_h_q;
    assign pwm_l   = pwm_l_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: per-cycle behavioural model plus directed
// waveform-width checks and a randomized soak.
module tb_pwm_deadtime;

    localparam int N    = 8;
    localparam int DT_W = 4;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [N-1:0]    cnt;
    logic            period_strobe;
    logic            wr_en;
    logic [N-1:0]    duty_in;
    logic [DT_W-1:0] dt_in;
    logic            pwm_h;
    logic            pwm_l;
    logic            pending;

    int vectors     = 0;
    int miscompares = 0;

    pwm_deadtime #(.N(N), .DT_W(DT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .cnt           (cnt),
        .period_strobe (period_strobe),
        .wr_en         (wr_en),
        .duty_in       (duty_in),
        .dt_in         (dt_in),
        .pwm_h         (pwm_h),
        .pwm_l         (pwm_l),
        .pending       (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Free-running upstream counter with a strobe while it reads zero.
    initial begin
        cnt           = '0;
        period_strobe = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cnt           = cnt + 1'b1;
            period_strobe = (cnt == '0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: drive side (0 off, 1 high, 2 low, 3 gap) and
    // number of gap cycles still to be shown.
    localparam int OFF = 0, DRV_H = 1, DRV_L = 2, GAP = 3;
    int m_stg_duty, m_stg_dt, m_act_duty, m_act_dt;
    int m_mode, m_left;
    bit m_pend, m_raw, m_tgt, armed;

    initial begin
        armed = 0;
        m_mode = OFF;
        m_left = 0;
    end

    always @(posedge clk) begin
        bit nraw;
        if (!rst_n) begin
            m_stg_duty = 0; m_stg_dt = 0; m_act_duty = 0; m_act_dt = 0;
            m_pend = 0; m_raw = 0; m_tgt = 0; m_mode = OFF; m_left = 0;
            armed = 1;
        end else begin
            nraw = en && (int'(cnt) < m_act_duty);
            if (!en) begin
                m_mode = OFF;
            end else if (m_mode == OFF || (m_mode == DRV_H && !m_raw) || (m_mode == DRV_L && m_raw)) begin
                m_tgt = m_raw;
                if (m_act_dt == 0) m_mode = m_raw ? DRV_H : DRV_L;
                else begin
                    m_mode = GAP;
                    m_left = m_act_dt;
                end
            end else if (m_mode == GAP) begin
                if (m_raw != m_tgt) begin
                    m_tgt  = m_raw;
                    m_left = (m_act_dt == 0) ? (1 << DT_W) : m_act_dt;
                end else if (m_left <= 1) begin
                    m_mode = m_tgt ? DRV_H : DRV_L;
                end else begin
                    m_left--;
                end
            end
            m_raw = nraw;
            if (period_strobe && m_pend) begin
                m_act_duty = m_stg_duty;
                m_act_dt   = m_stg_dt;
            end
            if (wr_en) begin
                m_stg_duty = int'(duty_in);
                m_stg_dt   = int'(dt_in);
                m_pend     = 1;
            end else if (period_strobe) begin
                m_pend = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("pwm_h", 32'(pwm_h), 32'(m_mode == DRV_H));
            check("pwm_l", 32'(pwm_l), 32'(m_mode == DRV_L));
            check("pending", 32'(pending), 32'(m_pend));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_cnt(input int v);
        for (int i = 0; i < 600; i++) begin
            if (int'(cnt) == v) return;
            cyc(1);
        end
        vectors++;
        miscompares++;
        $display("FAIL wait_cnt timeout: got %0d expected %0d", cnt, v);
    endtask

    task automatic write(input int d, input int t);
        wr_en   = 1'b1;
        duty_in = N'(d);
        dt_in   = DT_W'(t);
        cyc(1);
        wr_en   = 1'b0;
    endtask

    task automatic measure(input string tag, input int eh, input int el, input int ez);
        int h, l, z;
        h = 0; l = 0; z = 0;
        repeat (256) begin
            cyc(1);
            if (pwm_h) h++;
            if (pwm_l) l++;
            if (!pwm_h && !pwm_l) z++;
        end
        check({tag, "_h_width"}, 32'(h), 32'(eh));
        check({tag, "_l_width"}, 32'(l), 32'(el));
        check({tag, "_dead"}, 32'(z), 32'(ez));
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        wr_en   = 1'b1;
        duty_in = 8'hAA;
        dt_in   = 4'd5;
        cyc(2);
        check("rst_pwm_h", 32'(pwm_h), 0);
        check("rst_pwm_l", 32'(pwm_l), 0);
        check("rst_pending", 32'(pending), 0);

        rst_n = 1'b1;
        wr_en = 1'b0;
        en    = 1'b1;
        wait_cnt(0);
        wait_cnt(20);
        check("post_rst_pending", 32'(pending), 0);
        measure("duty0", 0, 256, 0);

        wait_cnt(100);
        write(64, 0);
        check("stage64_pending", 32'(pending), 1);
        wait_cnt(10);
        check("apply64_pending", 32'(pending), 0);
        measure("d64dt0", 64, 192, 0);
        wait_cnt(65);
        check("lag_h_last", 32'(pwm_h), 1);
        cyc(1);
        check("lag_h_fall", 32'(pwm_h), 0);
        check("lag_l_rise", 32'(pwm_l), 1);

        wait_cnt(100);
        write(128, 0);
        check("stage128_pending", 32'(pending), 1);
        wait_cnt(150);
        check("duty_held_64", 32'(pwm_h), 0);
        wait_cnt(10);
        check("apply128_pending", 32'(pending), 0);
        measure("d128", 128, 128, 0);

        wait_cnt(100);
        write(64, 3);
        wait_cnt(10);
        measure("d64dt3", 61, 189, 6);

        wait_cnt(0);
        write(32, 3);
        check("coinc_pending", 32'(pending), 1);
        wait_cnt(50);
        check("coinc_duty_held", 32'(pwm_h), 1);
        wait_cnt(10);
        check("coinc_applied_pending", 32'(pending), 0);
        measure("d32dt3", 29, 221, 6);

        wait_cnt(20);
        check("pre_drop_h", 32'(pwm_h), 1);
        en = 1'b0;
        cyc(1);
        check("drop_h", 32'(pwm_h), 0);
        check("drop_l", 32'(pwm_l), 0);
        wait_cnt(100);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("reen_dead_h", 32'(pwm_h), 0);
            check("reen_dead_l", 32'(pwm_l), 0);
        end
        cyc(1);
        check("reen_drive_l", 32'(pwm_l), 1);

        wait_cnt(100);
        write(255, 0);
        wait_cnt(10);
        measure("dmax", 255, 1, 0);

        for (int i = 0; i < 4000; i++) begin
            int sel;
            wr_en = ($urandom_range(0, 39) == 0) || (period_strobe && $urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 3);
            duty_in = (sel == 0) ? '0 : (sel == 1) ? '1 : N'($urandom);
            dt_in   = ($urandom_range(0, 2) == 0) ? '0 : DT_W'($urandom);
            if ($urandom_range(0, 149) == 0) en = ~en;
            rst_n = ($urandom_range(0, 499) != 0);
            cyc(1);
        end
        rst_n = 1'b1;
        wr_en = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime.md
PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 SHALL have parameter N, default 8, width of the counter value and duty registers.
REQ-002 SHALL have parameter DT_W, default 4, width of the dead-time register.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  output enable.
REQ-006 SHALL have port cnt  input  N  current value of the upstream free-running counter.
REQ-007 SHALL have port period_strobe  input  1  one-cycle pulse marking a counter period boundary.
REQ-008 SHALL have port wr_en  input  1  write strobe for the staging registers.
REQ-009 SHALL have port duty_in  input  N  duty value to stage.
REQ-010 SHALL have port dt_in  input  DT_W  dead-time value to stage, in clk cycles.
REQ-011 SHALL have port pwm_h  output  1  high-side drive.
REQ-012 SHALL have port pwm_l  output  1  low-side drive, complementary to pwm_h.
REQ-013 SHALL have port pending  output  1  staged values not yet applied.

Function
REQ-014 SHALL hold staging registers duty_stg/dt_stg and active registers duty_act/dt_act.
REQ-015 On wr_en: duty_stg<=duty_in, dt_stg<=dt_in, pending<=1.
REQ-016 On period_strobe with pending=1: duty_act<=duty_stg, dt_act<=dt_stg, pending<=0.
REQ-017 wr_en and period_strobe in the same cycle: active registers take the pre-write staging values if pending=1, else they are unchanged; staging takes the new inputs; pending=1 afterwards.
REQ-018 raw_q SHALL be registered as en && (cnt < duty_act), unsigned N-bit compare.
REQ-019 FSM states are IDLE, HIGH, LOW and DEAD; a registered target bit tgt and down-counter dt_cnt (DT_W bits) are kept.
REQ-020 pwm_h=1 only in HIGH and pwm_l=1 only in LOW; both are registered and never 1 simultaneously.
REQ-021 IDLE with en=1: tgt<=raw_q; go to the HIGH/LOW state per raw_q if dt_act==0, else go to DEAD with dt_cnt<=dt_act-1.
REQ-022 HIGH with raw_q=0, or LOW with raw_q=1: tgt<=raw_q; go to the opposite drive state directly if dt_act==0, else go to DEAD with dt_cnt<=dt_act-1.
REQ-023 DEAD with raw_q!=tgt: tgt<=raw_q and dt_cnt<=dt_act-1 (restart); else if dt_cnt==0, go to HIGH if tgt=1 or LOW if tgt=0; else decrement dt_cnt.
REQ-024 A dead phase SHALL keep both outputs low for exactly dt_act cycles.
REQ-025 en=0 in any state SHALL force IDLE on the next edge; the staging/active registers are unaffected.
REQ-026 With dt_act=0, pwm_h SHALL reflect (cnt<duty_act) with 2-cycle latency from cnt.
REQ-027 duty_act=0: pwm_l is steadily high. duty_act=2^N-1: pwm_h is low only for cnt=2^N-1.

Reset
REQ-028 With rst_n=0 at a rising edge, on that edge: state=IDLE; pwm_h=pwm_l=0; pending=0; raw_q=0; tgt=0; dt_cnt=0; all staging and active registers = 0.
REQ-029 Reset asserted mid-dead-phase or mid-pulse SHALL override all other inputs, including a simultaneous wr_en or period_strobe.

Verification
REQ-030 Hold rst_n=0 for 2 cycles with wr_en=1 -> pwm_h=pwm_l=pending=0; no staging register is loaded.
REQ-031 N=8, cnt sweeps 0..255 with period_strobe at cnt=0, write duty=64, dt=0 -> after the next strobe, each period has pwm_h high 64 cycles and pwm_l high 192 cycles, both lagging cnt by 2 cycles.
REQ-032 duty=64, dt=3 -> each edge has exactly 3 cycles with both outputs low; pwm_h width 61, pwm_l width 189.
REQ-033 Write duty=128 at cnt=100 -> pending=1 and duty stays 64 until the next strobe; then pending=0 and the pwm_h width becomes 128.
REQ-034 wr_en (duty=32) coincident with period_strobe while pending=0 -> the active duty is unchanged this period; pending=1; duty=32 applies at the following strobe.
REQ-035 With dt=3, drop en during HIGH -> both outputs are 0 on the next cycle; re-raise en -> 3 dead cycles, then the drive matching raw_q.
